hpdcache_tid_alloc: RTL and testbench

Transaction-ID allocator for the HPDcache miss/refill path. It holds a free list of `N_ID` identifiers, initialized full with IDs `0..N_ID-1` in ascending order. It shares that list between `N_REQ` requesters through a round-robin arbiter and accepts one ID release per cycle. Requesters are miss handler, uncached and CMO units; releases come from the memory-response demux.

---
 rtl/hpdcache_pkg.sv | 10 +
 rtl/hpdcache_tid_alloc_if.sv | 29 ++
 rtl/hpdcache_tid_rr_arb.sv | 45 ++++
 rtl/hpdcache_tid_alloc.sv | 92 +++++++++
 tb/tb_hpdcache_tid_alloc.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types and defaults used by the transaction-ID allocator.
package hpdcache_pkg;

  localparam int HPDCACHE_TID_ALLOC_NREQ = 2;
  localparam int HPDCACHE_TID_ALLOC_NID  = 8;
  localparam int HPDCACHE_TID_W          = $clog2(HPDCACHE_TID_ALLOC_NID);

  typedef logic [HPDCACHE_TID_W-1:0] hpdcache_tid_t;

endpackage

// File: rtl/hpdcache_tid_alloc_if.sv
// Allocation/release bundle between requesters, the response demux and the TID allocator.
// Handshake: a grant is a one-cycle accept of alloc_req_i (no ready, no locking);
// free_valid_i is always accepted the cycle it is high.
interface hpdcache_tid_alloc_if #(
  parameter int N_REQ = 2,
  parameter int N_ID  = 8
);
  localparam int ID_W  = $clog2(N_ID);
  localparam int CNT_W = $clog2(N_ID + 1);

  logic [N_REQ-1:0] alloc_req_i;
  logic [N_REQ-1:0] alloc_gnt_o;
  logic [ID_W-1:0]  alloc_id_o;
  logic             free_valid_i;
  logic [ID_W-1:0]  free_id_i;
  logic [CNT_W-1:0] free_count_o;
  logic             empty_o;
  logic             error_o;

  modport master (
    output alloc_req_i, free_valid_i, free_id_i,
    input  alloc_gnt_o, alloc_id_o, free_count_o, empty_o, error_o
  );

  modport slave (
    input  alloc_req_i, free_valid_i, free_id_i,
    output alloc_gnt_o, alloc_id_o, free_count_o, empty_o, error_o
  );
endinterface

// File: rtl/hpdcache_tid_rr_arb.sv
// Round-robin arbiter for TID allocation: one-hot grant, registered priority pointer.
module hpdcache_tid_rr_arb #(
  parameter int N_REQ = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     sum;
  logic [2*N_REQ-1:0] req_dbl;
  logic               hit;

  // Rotate requests so bit 0 is the current highest-priority requester.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_q;
    hit     = 1'b0;
    win     = '0;
    sum     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!hit && en_i && req_dbl[i]) begin
        hit = 1'b1;
        sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
        if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
        win = sum[PTR_W-1:0];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      gnt_o[k] = hit && (win == PTR_W'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (hit) begin
      ptr_q <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end
endmodule

// File: rtl/hpdcache_tid_alloc.sv
// HPDcache transaction-ID allocator: circular free list shared by round-robin requesters.
// Optional release checking with HPDCACHE_TID_ALLOC_CHECK_EN (outstanding bitmap, sticky error_o).
module hpdcache_tid_alloc
  import hpdcache_pkg::*;
#(
  parameter int N_REQ = HPDCACHE_TID_ALLOC_NREQ,
  parameter int N_ID  = HPDCACHE_TID_ALLOC_NID,
  localparam int ID_W  = $clog2(N_ID),
  localparam int CNT_W = $clog2(N_ID + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hpdcache_tid_alloc_if.slave bus
);
  logic [ID_W-1:0]  list_q [N_ID];
  logic [ID_W-1:0]  rptr_q;
  logic [ID_W-1:0]  wptr_q;
  logic [CNT_W-1:0] count_q;
  logic [N_REQ-1:0] gnt;
  logic             empty;
  logic             alloc;
  logic             push;

  assign empty = (count_q == '0);

  hpdcache_tid_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (bus.alloc_req_i),
    .en_i  (!empty && !rst_i),
    .gnt_o (gnt)
  );

  assign alloc            = |gnt;
  assign bus.alloc_gnt_o  = gnt;
  assign bus.alloc_id_o   = list_q[rptr_q];
  assign bus.free_count_o = count_q;
  assign bus.empty_o      = empty;

`ifdef HPDCACHE_TID_ALLOC_CHECK_EN
  logic [N_ID-1:0] outst_q;
  logic            err_q;
  logic            bad_free;

  // A release is illegal if the ID is not outstanding or the list is already full.
  assign bad_free    = bus.free_valid_i &&
                       (!outst_q[bus.free_id_i] || count_q == CNT_W'(N_ID));
  assign push        = bus.free_valid_i && !bad_free && !rst_i;
  assign bus.error_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (alloc) outst_q[list_q[rptr_q]] <= 1'b1;
      if (push)  outst_q[bus.free_id_i] <= 1'b0;
      if (bad_free) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(gnt));
      assert (count_q <= CNT_W'(N_ID));
    end
  end
`else
  assign push        = bus.free_valid_i && !rst_i;
  assign bus.error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ID; i++) list_q[i] <= ID_W'(i);
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= CNT_W'(N_ID);
    end else begin
      if (alloc) rptr_q <= rptr_q + ID_W'(1);
      if (push) begin
        list_q[wptr_q] <= bus.free_id_i;
        wptr_q         <= wptr_q + ID_W'(1);
      end
      case ({alloc, push})
        2'b10:   count_q <= count_q - CNT_W'(1);
        2'b01:   count_q <= count_q + CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_hpdcache_tid_alloc.sv
// Directed bench for hpdcache_tid_alloc (N_REQ=2, N_ID=4) with a grant/ID scoreboard.
module tb_hpdcache_tid_alloc;
  localparam int N_REQ = 2;
  localparam int N_ID  = 4;
  localparam int ID_W  = 2;
  localparam int W     = N_REQ + ID_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  hpdcache_tid_alloc_if #(.N_REQ(N_REQ), .N_ID(N_ID)) bus ();

  hpdcache_tid_alloc #(.N_REQ(N_REQ), .N_ID(N_ID)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Pop the expected {grant, id} and compare against the DUT; id is don't-care without a grant.
  task automatic sb_check(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] o;
    o = {bus.alloc_gnt_o, (bus.alloc_gnt_o != '0) ? bus.alloc_id_o : {ID_W{1'b0}}};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, got %0h", tag, o);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(o), 32'(e));
    end
  endtask

  // One cycle: drive inputs, expect grant/id this cycle and registered status from before it.
  task automatic cyc(input string tag, input logic [1:0] req, input logic fv, input logic [1:0] fid,
                     input logic [1:0] e_gnt, input logic [1:0] e_id, input int e_cnt,
                     input logic e_empty, input logic e_err);
    bus.alloc_req_i  = req;
    bus.free_valid_i = fv;
    bus.free_id_i    = fid;
    exp_q.push_back({e_gnt, (e_gnt != 2'b00) ? e_id : 2'b00});
    @(negedge clk);
    sb_check({tag, "_gnt"});
    chk({tag, "_cnt"}, 32'(bus.free_count_o), 32'(e_cnt));
    chk({tag, "_empty"}, 32'(bus.empty_o), 32'(e_empty));
    chk({tag, "_err"}, 32'(bus.error_o), 32'(e_err));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag, input logic [1:0] req);
    rst              = 1'b1;
    bus.alloc_req_i  = req;
    bus.free_valid_i = 1'b1;
    bus.free_id_i    = 2'd1;
    exp_q.push_back('0);
    @(negedge clk);
    sb_check({tag, "_gnt_in_reset"});
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.free_valid_i = 1'b0;
  endtask

  initial begin
    bus.alloc_req_i  = '0;
    bus.free_valid_i = 1'b0;
    bus.free_id_i    = '0;
    @(posedge clk);
    #1;
    reset_pulse("init", 2'b01);

    // Single requester drains the list in ascending order.
    cyc("s1c1", 2'b01, 0, 0, 2'b01, 2'd0, 4, 0, 0);
    cyc("s1c2", 2'b01, 0, 0, 2'b01, 2'd1, 3, 0, 0);
    cyc("s1c3", 2'b01, 0, 0, 2'b01, 2'd2, 2, 0, 0);
    cyc("s1c4", 2'b01, 0, 0, 2'b01, 2'd3, 1, 0, 0);
    cyc("s1c5", 2'b01, 0, 0, 2'b00, 2'd0, 0, 1, 0);

    // Release while empty: no bypass, granted next cycle.
    cyc("rel_c1", 2'b01, 1, 2'd2, 2'b00, 2'd0, 0, 1, 0);
    cyc("rel_c2", 2'b01, 0, 0,    2'b01, 2'd2, 1, 0, 0);
    cyc("rel_c3", 2'b00, 1, 2'd1, 2'b00, 2'd0, 0, 1, 0);
    // Count 1 with head ID 1: simultaneous alloc and release of ID 3.
    cyc("sim_c1", 2'b01, 1, 2'd3, 2'b01, 2'd1, 1, 0, 0);
    cyc("sim_c2", 2'b01, 0, 0,    2'b01, 2'd3, 1, 0, 0);
    cyc("sim_c3", 2'b00, 0, 0,    2'b00, 2'd0, 0, 1, 0);

    // Both requesting: grants alternate.
    reset_pulse("rst2", 2'b11);
    cyc("rr_c1", 2'b11, 0, 0, 2'b01, 2'd0, 4, 0, 0);
    cyc("rr_c2", 2'b11, 0, 0, 2'b10, 2'd1, 3, 0, 0);
    cyc("rr_c3", 2'b11, 0, 0, 2'b01, 2'd2, 2, 0, 0);
    cyc("rr_c4", 2'b11, 0, 0, 2'b10, 2'd3, 1, 0, 0);
    cyc("rr_c5", 2'b11, 0, 0, 2'b00, 2'd0, 0, 1, 0);

`ifdef HPDCACHE_TID_ALLOC_CHECK_EN
    // Illegal release of a non-outstanding ID: dropped, sticky error.
    reset_pulse("rst3", 2'b00);
    cyc("bad_c1", 2'b00, 1, 2'd3, 2'b00, 2'd0, 4, 0, 0);
    cyc("bad_c2", 2'b01, 0, 0,    2'b01, 2'd0, 4, 0, 1);
    cyc("bad_c3", 2'b00, 1, 2'd2, 2'b00, 2'd0, 3, 0, 1);
    cyc("bad_c4", 2'b00, 0, 0,    2'b00, 2'd0, 3, 0, 1);
`endif

    // Mid-operation reset restores the full ascending list.
    reset_pulse("rst4", 2'b00);
    cyc("mr_a1", 2'b01, 0, 0, 2'b01, 2'd0, 4, 0, 0);
    cyc("mr_a2", 2'b01, 0, 0, 2'b01, 2'd1, 3, 0, 0);
    cyc("mr_a3", 2'b01, 0, 0, 2'b01, 2'd2, 2, 0, 0);
    reset_pulse("rst5", 2'b01);
    cyc("mr_c1", 2'b01, 0, 0, 2'b01, 2'd0, 4, 0, 0);
    cyc("mr_c2", 2'b11, 0, 0, 2'b10, 2'd1, 3, 0, 0);
    cyc("mr_c3", 2'b01, 0, 0, 2'b01, 2'd2, 2, 0, 0);
    cyc("mr_c4", 2'b01, 0, 0, 2'b01, 2'd3, 1, 0, 0);
    cyc("mr_c5", 2'b00, 0, 0, 2'b00, 2'd0, 0, 1, 0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
